// File: rtl/pow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pow_pkg
// Description : Shared definitions for the pow_fsmd_param exponentiation block.
//               Holds the controller state encodings and the overflow test
//               applied to the double-width products.
// Revision    : 1.0 - initial release
// ============================================================================
package pow_pkg;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_CHECK = 3'b010;
    localparam logic [2:0] S_EVEN  = 3'b011;
    localparam logic [2:0] S_ODD   = 3'b100;
    localparam logic [2:0] S_DONE  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_CHECK = S_CHECK,
        ST_EVEN  = S_EVEN,
        ST_ODD   = S_ODD,
        ST_DONE  = S_DONE
    } state_t;

    // Widest result register the overflow helper supports.
    localparam int unsigned MAX_RES_W = 64;

    // True when any bit at or above position res_w of a product is set, i.e.
    // the product does not fit in the res_w-bit result register. Products
    // narrower than 2*MAX_RES_W are zero-extended by the caller.
    function automatic logic upper_nonzero(input logic [2*MAX_RES_W-1:0] prod,
                                           input int unsigned            res_w);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < 2*MAX_RES_W; i++) begin
            if (i >= res_w && prod[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pow_fsmd_param_if.sv
`default_nettype none
// ============================================================================
// Module      : pow_fsmd_param_if
// Description : Go/done handshake and operand/result bundle of pow_fsmd_param.
//   go_i     start request          abort_i  synchronous abort
//   base_i   base operand           exp_i    exponent
//   busy_o   operation in progress  done_o   one-cycle completion pulse
//   result_o registered result      ovf_o    overflow flag of last result
//   state_o  controller state (debug / LCD readout)
//   master : requester side, slave : pow_fsmd_param side
// Revision    : 1.0 - initial release
// ============================================================================
interface pow_fsmd_param_if #(
    parameter int unsigned BASE_W = 8,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned RES_W  = 16
);
    logic              go_i;
    logic              abort_i;
    logic [BASE_W-1:0] base_i;
    logic [EXP_W-1:0]  exp_i;
    logic              busy_o;
    logic              done_o;
    logic [RES_W-1:0]  result_o;
    logic              ovf_o;
    logic [2:0]        state_o;

    modport master (
        output go_i, abort_i, base_i, exp_i,
        input  busy_o, done_o, result_o, ovf_o, state_o
    );

    modport slave (
        input  go_i, abort_i, base_i, exp_i,
        output busy_o, done_o, result_o, ovf_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/pow_datapath.sv
`default_nettype none
// ============================================================================
// Module      : pow_datapath
// Description : Square-and-multiply datapath: running square a, remaining
//               exponent n, accumulator acc and sticky overflow flag.
//   clk, rst      clock, asynchronous active-low reset
//   ld_op         latch base/exp into a/n
//   ld_init       acc <= 1, clear overflow
//   sel_sq        a <= a*a, n <= n>>1
//   sel_mul       acc <= acc*a (uses the pre-square a)
//   n_zero/n_lsb  exponent status for the controller
//   acc/ovf_int   running result and overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module pow_datapath
    import pow_pkg::*;
#(
    parameter int unsigned BASE_W = 8,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned RES_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              ld_op,
    input  wire logic              ld_init,
    input  wire logic              sel_sq,
    input  wire logic              sel_mul,
    input  wire logic [BASE_W-1:0] base_in,
    input  wire logic [EXP_W-1:0]  exp_in,
    output logic                   n_zero,
    output logic                   n_lsb,
    output logic [RES_W-1:0]       acc,
    output logic                   ovf_int
);
    logic [RES_W-1:0]   a;
    logic [EXP_W-1:0]   n;
    logic [2*RES_W-1:0] sq;
    logic [2*RES_W-1:0] mul;
    logic               n_more;
    logic               sq_ovf;
    logic               mul_ovf;

    assign sq  = {{RES_W{1'b0}}, a}   * {{RES_W{1'b0}}, a};
    assign mul = {{RES_W{1'b0}}, acc} * {{RES_W{1'b0}}, a};

    assign n_zero = (n == '0);
    assign n_lsb  = n[0];
    assign n_more = ((n >> 1) != '0);

    // A square that is never consumed (last exponent bit) must not flag.
    assign sq_ovf  = upper_nonzero((2*MAX_RES_W)'(sq), RES_W) && n_more;
    assign mul_ovf = upper_nonzero((2*MAX_RES_W)'(mul), RES_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a       <= '0;
            n       <= '0;
            acc     <= '0;
            ovf_int <= 1'b0;
        end else begin
            if (ld_op) begin
                a <= RES_W'(base_in);
                n <= exp_in;
            end
            if (ld_init) begin
                acc     <= RES_W'(1);
                ovf_int <= 1'b0;
            end
            if (sel_sq) begin
                a <= sq[RES_W-1:0];
                n <= n >> 1;
                if (sq_ovf) begin
                    ovf_int <= 1'b1;
                end
            end
            if (sel_mul) begin
                acc <= mul[RES_W-1:0];
                if (mul_ovf) begin
                    ovf_int <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/pow_fsmd_param.sv
`default_nettype none
// ============================================================================
// Module      : pow_fsmd_param
// Description : Parametrised base^exp engine (right-to-left square-and-
//               multiply) with go/done handshake, overflow flag, optional
//               saturation and synchronous abort.
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   pow_fsmd_param_if.slave: go/abort/operands in, busy/done/
//         result/ovf/state out
// Revision    : 1.0 - initial release
// ============================================================================
module pow_fsmd_param
    import pow_pkg::*;
#(
    parameter int unsigned BASE_W = 8,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned RES_W  = 16,
    parameter bit          SAT    = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pow_fsmd_param_if.slave   bus
);
    state_t           state;
    logic             ld_op;
    logic             ld_init;
    logic             sel_sq;
    logic             sel_mul;
    logic             n_zero;
    logic             n_lsb;
    logic [RES_W-1:0] acc;
    logic             ovf_int;
    logic             aborting;

    // Abort only matters outside IDLE; there it overrides every strobe so the
    // datapath does not advance on the aborting edge.
    assign aborting = bus.abort_i && (state != ST_IDLE);
    assign ld_op    = (state == ST_IDLE) && bus.go_i;
    assign ld_init  = (state == ST_LOAD) && !aborting;
    assign sel_sq   = ((state == ST_EVEN) || (state == ST_ODD)) && !aborting;
    assign sel_mul  = (state == ST_ODD) && !aborting;

    assign bus.state_o = state;

    pow_datapath #(
        .BASE_W (BASE_W),
        .EXP_W  (EXP_W),
        .RES_W  (RES_W)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .ld_op   (ld_op),
        .ld_init (ld_init),
        .sel_sq  (sel_sq),
        .sel_mul (sel_mul),
        .base_in (bus.base_i),
        .exp_in  (bus.exp_i),
        .n_zero  (n_zero),
        .n_lsb   (n_lsb),
        .acc     (acc),
        .ovf_int (ovf_int)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            bus.busy_o   <= 1'b0;
            bus.done_o   <= 1'b0;
            bus.result_o <= '0;
            bus.ovf_o    <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            if (aborting) begin
                state      <= ST_IDLE;
                bus.busy_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.go_i) begin
                            state      <= ST_LOAD;
                            bus.busy_o <= 1'b1;
                        end
                    end
                    ST_LOAD:  state <= ST_CHECK;
                    ST_CHECK: begin
                        if (n_zero)      state <= ST_DONE;
                        else if (!n_lsb) state <= ST_EVEN;
                        else             state <= ST_ODD;
                    end
                    ST_EVEN:  state <= ST_CHECK;
                    ST_ODD:   state <= ST_CHECK;
                    ST_DONE: begin
                        state        <= ST_IDLE;
                        bus.busy_o   <= 1'b0;
                        bus.done_o   <= 1'b1;
                        bus.result_o <= (SAT && ovf_int) ? '1 : acc;
                        bus.ovf_o    <= ovf_int;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        bus.busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pow_fsmd_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_pow_fsmd_param
// Description : Directed self-checking bench for pow_fsmd_param. Two
//               instances (SAT=0 and SAT=1) share clock, reset and stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pow_fsmd_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       abort;
    logic [7:0] base;
    logic [7:0] exp;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    pow_fsmd_param_if #(.BASE_W(8), .EXP_W(8), .RES_W(16)) bus0 ();
    pow_fsmd_param_if #(.BASE_W(8), .EXP_W(8), .RES_W(16)) bus1 ();

    assign bus0.go_i    = go;
    assign bus0.abort_i = abort;
    assign bus0.base_i  = base;
    assign bus0.exp_i   = exp;
    assign bus1.go_i    = go;
    assign bus1.abort_i = abort;
    assign bus1.base_i  = base;
    assign bus1.exp_i   = exp;

    pow_fsmd_param #(.BASE_W(8), .EXP_W(8), .RES_W(16), .SAT(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pow_fsmd_param #(.BASE_W(8), .EXP_W(8), .RES_W(16), .SAT(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Issue one go pulse and count edges until done_o (sampled on negedges).
    task automatic run_op(input logic [7:0] b, input logic [7:0] e,
                          output int cyc, output int bcnt, output bit seen);
        @(negedge clk);
        base = b; exp = e; go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0; cyc = 0; bcnt = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus0.done_o) begin
                seen = 1'b1;
                break;
            end
            if (bus0.busy_o) bcnt++;
            @(posedge clk); cyc++;
            @(negedge clk);
        end
    endtask

    // Wait for done_o from the current negedge, counting edges.
    task automatic wait_done(output int cyc, output bit seen);
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == 3 && go) go = 1'b0;
            if (bus0.done_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; go = 1'b0; abort = 1'b0; base = '0; exp = '0;
        #3;
        checks++;
        if (bus0.state_o !== 3'b000 || bus0.result_o !== 16'd0 || bus0.done_o !== 1'b0
            || bus0.ovf_o !== 1'b0 || bus0.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset: state=%b result=%0d done=%b ovf=%b busy=%b, want 000/0/0/0/0",
                     bus0.state_o, bus0.result_o, bus0.done_o, bus0.ovf_o, bus0.busy_o);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc; int bcnt; bit seen;
        run_op(8'd3, 8'd5, cyc, bcnt, seen);
        checks++;
        if (!seen || cyc !== 9) begin
            failures++; $display("FAIL basic_latency: seen=%b cycles=%0d, want 9", seen, cyc);
        end
        checks++;
        if (bcnt !== 9) begin
            failures++; $display("FAIL basic_busy: busy cycles=%0d, want 9", bcnt);
        end
        checks++;
        if (bus0.result_o !== 16'd243 || bus0.ovf_o !== 1'b0) begin
            failures++; $display("FAIL basic_3pow5: result=%0d ovf=%b, want 243/0", bus0.result_o, bus0.ovf_o);
        end
        checks++;
        if (bus1.result_o !== 16'd243 || bus1.ovf_o !== 1'b0) begin
            failures++; $display("FAIL basic_sat_3pow5: result=%0d ovf=%b, want 243/0", bus1.result_o, bus1.ovf_o);
        end
    endtask

    task automatic test_exp_zero();
        int cyc; int bcnt; bit seen;
        run_op(8'd7, 8'd0, cyc, bcnt, seen);
        checks++;
        if (!seen || cyc !== 3 || bus0.result_o !== 16'd1) begin
            failures++; $display("FAIL exp0_7: seen=%b cycles=%0d result=%0d, want 3/1", seen, cyc, bus0.result_o);
        end
        run_op(8'd0, 8'd0, cyc, bcnt, seen);
        checks++;
        if (!seen || bus0.result_o !== 16'd1 || bus0.ovf_o !== 1'b0) begin
            failures++; $display("FAIL zero_pow_zero: result=%0d ovf=%b, want 1/0", bus0.result_o, bus0.ovf_o);
        end
        run_op(8'd0, 8'd4, cyc, bcnt, seen);
        checks++;
        if (!seen || cyc !== 9 || bus0.result_o !== 16'd0 || bus0.ovf_o !== 1'b0) begin
            failures++; $display("FAIL zero_pow_4: cycles=%0d result=%0d ovf=%b, want 9/0/0", cyc, bus0.result_o, bus0.ovf_o);
        end
    endtask

    task automatic test_overflow();
        int cyc; int bcnt; bit seen;
        run_op(8'd2, 8'd16, cyc, bcnt, seen);
        checks++;
        if (!seen || bus0.result_o !== 16'd0 || bus0.ovf_o !== 1'b1) begin
            failures++; $display("FAIL ovf_wrap_2pow16: result=%h ovf=%b, want 0000/1", bus0.result_o, bus0.ovf_o);
        end
        checks++;
        if (bus1.result_o !== 16'hFFFF || bus1.ovf_o !== 1'b1) begin
            failures++; $display("FAIL ovf_sat_2pow16: result=%h ovf=%b, want ffff/1", bus1.result_o, bus1.ovf_o);
        end
        run_op(8'd255, 8'd2, cyc, bcnt, seen);
        checks++;
        if (!seen || bus0.result_o !== 16'd65025 || bus0.ovf_o !== 1'b0
            || bus1.result_o !== 16'd65025 || bus1.ovf_o !== 1'b0) begin
            failures++; $display("FAIL unused_square_255pow2: r0=%0d o0=%b r1=%0d o1=%b, want 65025/0 both",
                                 bus0.result_o, bus0.ovf_o, bus1.result_o, bus1.ovf_o);
        end
        // 255^3 = 16581375 -> low 16 bits 767, overflow from the multiply.
        run_op(8'd255, 8'd3, cyc, bcnt, seen);
        checks++;
        if (!seen || bus0.result_o !== 16'd767 || bus0.ovf_o !== 1'b1
            || bus1.result_o !== 16'hFFFF || bus1.ovf_o !== 1'b1) begin
            failures++; $display("FAIL mul_ovf_255pow3: r0=%0d o0=%b r1=%h o1=%b, want 767/1 ffff/1",
                                 bus0.result_o, bus0.ovf_o, bus1.result_o, bus1.ovf_o);
        end
    endtask

    task automatic test_handshake();
        int cyc; bit seen; int extra_done;
        // go held high, operands changed after acceptance.
        @(negedge clk); base = 8'd3; exp = 8'd5; go = 1'b1;
        @(posedge clk);
        @(negedge clk); base = 8'd5; exp = 8'd2;
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus0.done_o) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || cyc !== 9 || bus0.result_o !== 16'd243) begin
            failures++; $display("FAIL held_go_latched: cycles=%0d result=%0d, want 9/243", cyc, bus0.result_o);
        end
        // go still high in the done cycle -> accepted on the next edge.
        @(posedge clk);
        @(negedge clk); go = 1'b0;
        checks++;
        if (bus0.state_o !== 3'b001) begin
            failures++; $display("FAIL back_to_back_start: state=%b, want 001", bus0.state_o);
        end
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus0.done_o) begin seen = 1'b1; break; end
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        checks++;
        if (!seen || cyc !== 7 || bus0.result_o !== 16'd25) begin
            failures++; $display("FAIL back_to_back_result: cycles=%0d result=%0d, want 7/25", cyc, bus0.result_o);
        end
        // go pulse while busy must be ignored.
        @(negedge clk); base = 8'd2; exp = 8'd3; go = 1'b1;
        @(posedge clk);
        @(negedge clk); go = 1'b0;
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == 2) begin go = 1'b1; base = 8'd9; exp = 8'd1; end
            if (cyc == 3) go = 1'b0;
            if (bus0.done_o) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || cyc !== 7 || bus0.result_o !== 16'd8) begin
            failures++; $display("FAIL busy_go_ignored: cycles=%0d result=%0d, want 7/8", cyc, bus0.result_o);
        end
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus0.done_o || bus0.busy_o) extra_done++;
        end
        checks++;
        if (extra_done !== 0) begin
            failures++; $display("FAIL busy_go_no_rerun: extra busy/done cycles=%0d, want 0", extra_done);
        end
    endtask

    task automatic test_abort();
        int cyc; bit seen; int dones;
        @(negedge clk); base = 8'd3; exp = 8'd5; go = 1'b1;
        @(posedge clk);
        @(negedge clk); go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk); abort = 1'b0;
        checks++;
        if (bus0.state_o !== 3'b000 || bus0.busy_o !== 1'b0 || bus0.done_o !== 1'b0
            || bus0.result_o !== 16'd8) begin
            failures++; $display("FAIL abort_idle: state=%b busy=%b done=%b result=%0d, want 000/0/0/8",
                                 bus0.state_o, bus0.busy_o, bus0.done_o, bus0.result_o);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus0.done_o) dones++;
        end
        checks++;
        if (dones !== 0 || bus0.result_o !== 16'd8) begin
            failures++; $display("FAIL abort_no_done: dones=%0d result=%0d, want 0/8", dones, bus0.result_o);
        end
        // abort in IDLE does not block go.
        @(negedge clk); base = 8'd3; exp = 8'd5; go = 1'b1; abort = 1'b1;
        @(posedge clk);
        @(negedge clk); go = 1'b0; abort = 1'b0;
        checks++;
        if (bus0.state_o !== 3'b001) begin
            failures++; $display("FAIL abort_in_idle: state=%b, want 001", bus0.state_o);
        end
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc !== 9 || bus0.result_o !== 16'd243) begin
            failures++; $display("FAIL after_abort_run: cycles=%0d result=%0d, want 9/243", cyc, bus0.result_o);
        end
    endtask

    task automatic test_async_reset();
        int cyc; int bcnt; bit seen;
        @(negedge clk); base = 8'd2; exp = 8'd3; go = 1'b1;
        @(posedge clk);
        @(negedge clk); go = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus0.state_o !== 3'b000 || bus0.result_o !== 16'd0 || bus0.done_o !== 1'b0
            || bus0.busy_o !== 1'b0 || bus0.ovf_o !== 1'b0) begin
            failures++; $display("FAIL async_reset: state=%b result=%0d done=%b busy=%b ovf=%b, want 000/0/0/0/0",
                                 bus0.state_o, bus0.result_o, bus0.done_o, bus0.busy_o, bus0.ovf_o);
        end
        @(negedge clk); rst = 1'b1;
        run_op(8'd3, 8'd5, cyc, bcnt, seen);
        checks++;
        if (!seen || cyc !== 9 || bus0.result_o !== 16'd243) begin
            failures++; $display("FAIL post_reset_run: cycles=%0d result=%0d, want 9/243", cyc, bus0.result_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exp_zero();
        test_overflow();
        test_handshake();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pow_fsmd_param.md
Name: pow_fsmd_param

Overview:
- Parametrised exponentiation FSMD: computes base_i^exp_i by right-to-left square-and-multiply.
- Controller and datapath live in one block, with a registered result, a go/done handshake, overflow detection, an optional saturation mode and a synchronous abort.
- Feeds the LCD display path: result_o/ovf_o go to the display formatter, state_o to the debug readout.
- Successor to the fixed 8-bit exponent controller, generalised in operand width and result width.

Parameters:
- BASE_W, 8, base operand width.
- EXP_W, 8, exponent width.
- RES_W, 16, result width and internal a/result register width (RES_W >= BASE_W).
- SAT, 0, overflow policy: 0 = result is the true value mod 2^RES_W; 1 = result forced to all-ones on overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- go_i  in  1  start request; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE.
- base_i  in  BASE_W  base operand; latched on accepted go.
- exp_i  in  EXP_W  exponent; latched on accepted go.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when result_o/ovf_o update.
- result_o  out  RES_W  registered result; held until next completion.
- ovf_o  out  1  registered overflow flag for the last result.
- state_o  out  3  current state encoding (debug/LCD).

Behaviour:
- Reset (rst low, async): state=IDLE; a, n, acc, result_o=0; ovf_o=0; done_o=0.
- State encodings: IDLE=000, LOAD=001, CHECK=010, EVEN=011, ODD=100, DONE=101. Unused codes go to IDLE.
- IDLE:
  - go_i=1 -> LOAD; latch base_i zero-extended into a, exp_i into n.
  - go_i is ignored in all other states; operand changes after acceptance are ignored.
- LOAD: acc<=1, ovf_int<=0; -> CHECK.
- CHECK: n==0 -> DONE; else n[0]==0 -> EVEN; else ODD.
- EVEN: a<=a*a (low RES_W bits); n<=n>>1; -> CHECK.
- ODD: acc<=acc*a, then a<=a*a; n<=n>>1; -> CHECK. Both products use the old a.
- Products are formed at 2*RES_W width. Overflow detection:
  - ovf_int set (sticky) if the upper RES_W bits of acc*a are nonzero in ODD.
  - ovf_int set if the upper bits of a*a are nonzero and (n>>1)!=0 in EVEN/ODD. A square that will never be used does not flag.
- DONE -> IDLE. On that edge:
  - result_o <= (SAT && ovf_int) ? all-ones : acc.
  - ovf_o <= ovf_int.
  - done_o <= 1.
- done_o returns to 0 on the next edge.
- Latency: go sampled at edge E0; done_o high after edge E0+3+2k, where k = position of MSB of exp_i + 1 (k=0 for exp=0).
- exp=0 returns 1 for any base, including 0^0=1.
- base=0 with exp>0 returns 0 with no overflow.
- abort_i=1 in any non-IDLE state -> IDLE on next edge:
  - result_o and ovf_o unchanged; no done pulse.
  - abort_i has priority over all transitions; in IDLE it has no effect and does not block go_i.
- A go_i in the cycle done_o is high is accepted, since the state is already IDLE.
- Reset mid-operation: immediate return to reset values; the previous result is lost.

Decomposition:
- Package pow_pkg holds the state encodings (localparams) and a function for the overflow test of a 2*RES_W product.
- One natural sub-module: pow_datapath, containing the a/n/acc registers, multipliers and overflow logic. It is driven by ld/sel strobes from the FSM in pow_fsmd_param.

Test Plan:
- BASE_W=8, EXP_W=8, RES_W=16, SAT=0; base=3, exp=5 -> done_o 9 cycles after go, result_o=243, ovf_o=0; busy_o high for 9 cycles.
- base=7, exp=0 -> done_o after 3 cycles, result_o=1. Then base=0, exp=0 -> 1. Then base=0, exp=4 -> 0, ovf_o=0.
- base=2, exp=16, SAT=0 -> result_o=0, ovf_o=1. Same stimulus with SAT=1 -> result_o=16'hFFFF, ovf_o=1. base=255, exp=2 -> 65025, ovf_o=0.
- Handshake: go_i held high across a run with operands changed mid-run -> the first result uses the latched operands. A second run starts in the cycle after done_o. A go pulse during busy is ignored.
- Abort: start 3^5, assert abort_i at cycle 4 -> IDLE next edge, no done_o, result_o keeps the prior value; the next go completes correctly.
- Reset: drop rst mid-run (asynchronous, between edges) -> state_o=000, result_o=0, done_o=0 immediately; normal operation after release.
